// File: rtl/vga_framebuffer.sv
// vga_framebuffer: 160x120x3 frame store with write port, scanned out as 640x480@60 VGA in 4x4 blocks
module vga_framebuffer #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       writeEn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_VIS = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SS = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SE = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SS = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SE = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [2:0] mem [0:19199];
  logic phase, tick;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [14:0] waddr, raddr_c, raddr, rv, rh;
  logic we, vis_c, hs_c, vs_c, h_last, v_last;
  logic vis1, hs1, vs1, vis2, hs2, vs2;
  logic [2:0] pix;

  assign tick = phase;
  assign vga_clk = phase;
  assign vga_sync_n = 1'b0;
  assign we = writeEn && x < 8'd160 && y < 7'd120;
  assign waddr = ({8'b0, y} << 7) + ({8'b0, y} << 5) + {7'b0, x};
  assign rv = 15'(v_cnt >> 2);
  assign rh = 15'(h_cnt >> 2);
  assign raddr_c = (rv << 7) + (rv << 5) + rh;
  assign vis_c = h_cnt < H_VIS && v_cnt < V_VIS;
  assign hs_c = h_cnt >= H_SS && h_cnt < H_SE;
  assign vs_c = v_cnt >= V_SS && v_cnt < V_SE;
  assign h_last = h_cnt == H_LAST;
  assign v_last = v_cnt == V_LAST;

  // RAM ports are not reset so stored pixels survive a reset, and read-before-write falls out of NBA
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= colour;
    if (tick) pix <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
      raddr <= '0;
      {vis1, hs1, vs1, vis2, hs2, vs2} <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      phase <= ~phase;
      if (tick) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        raddr <= raddr_c;
        {vis1, hs1, vs1} <= {vis_c, hs_c, vs_c};
        {vis2, hs2, vs2} <= {vis1, hs1, vs1};
        vga_r <= vis2 ? {8{pix[2]}} : 8'h00;
        vga_g <= vis2 ? {8{pix[1]}} : 8'h00;
        vga_b <= vis2 ? {8{pix[0]}} : 8'h00;
        vga_hs <= ~hs2;
        vga_vs <= ~vs2;
        vga_blank_n <= vis2;
      end
    end
  end
endmodule

// File: tb/tb_vga_framebuffer.sv
// tb_vga_framebuffer: scoreboard bench; small-timing instance s covers whole frames, default instance d covers line 0
module tb_vga_framebuffer;
  logic clk = 1'b0, reset = 1'b1, writeEn = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic s_clk, s_hs, s_vs, s_blank_n, s_sync_n, d_clk, d_hs, d_vs, d_blank_n, d_sync_n;
  logic [7:0] s_r, s_g, s_b, d_r, d_g, d_b;
  logic [28:0] obs_s, obs_d, got;
  int cyc = 0, compared = 0, mismatched = 0, r0, r2, q;
  int q_at[$];
  logic [28:0] q_exp[$];
  bit q_sel[$];
  string q_nm[$];
  logic [2:0] mdl [0:3][0:7];

  vga_framebuffer #(.H_VISIBLE(32), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
                    .V_VISIBLE(16), .V_FRONT(2), .V_SYNC(3), .V_BACK(3)) s (
    .clk(clk), .reset(reset), .writeEn(writeEn), .x(x), .y(y), .colour(colour),
    .vga_clk(s_clk), .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank_n(s_blank_n),
    .vga_sync_n(s_sync_n), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b));

  vga_framebuffer d (
    .clk(clk), .reset(reset), .writeEn(writeEn), .x(x), .y(y), .colour(colour),
    .vga_clk(d_clk), .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank_n(d_blank_n),
    .vga_sync_n(d_sync_n), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b));

  assign obs_s = {s_clk, s_sync_n, s_hs, s_vs, s_blank_n, s_r, s_g, s_b};
  assign obs_d = {d_clk, d_sync_n, d_hs, d_vs, d_blank_n, d_r, d_g, d_b};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [28:0] mk(input logic c, input logic hs_a, input logic vs_a,
                                     input logic vis, input logic [2:0] p);
    return {c, 1'b0, ~hs_a, ~vs_a, vis,
            vis ? {{8{p[2]}}, {8{p[1]}}, {8{p[0]}}} : 24'h0};
  endfunction

  task automatic push(input int at, input bit sel, input logic [28:0] e, input string nm);
    q_at.push_back(at);
    q_sel.push_back(sel);
    q_exp.push_back(e);
    q_nm.push_back(nm);
  endtask

  // small instance: position n = v*48 + h shows at cycle base + 5 + 2n
  function automatic int ps(input int b, input int h, input int v);
    return b + 5 + 2 * (v * 48 + h);
  endfunction

  task automatic push_rst(input int r);
    for (int k = 0; k < 5; k++) begin
      push(r + k, 1'b0, mk(k % 2 == 0, 0, 0, 0, 3'b0), $sformatf("rst_s_%0d", k));
      push(r + k, 1'b1, mk(k % 2 == 0, 0, 0, 0, 3'b0), $sformatf("rst_d_%0d", k));
    end
  endtask

  task automatic push_frame(input int b, input string tag);
    for (int v = 0; v < 16; v++)
      for (int h = 0; h < 32; h++)
        push(ps(b, h, v), 1'b0, mk(0, 0, 0, 1, mdl[v >> 2][h >> 2]),
             $sformatf("%s_h%0d_v%0d", tag, h, v));
  endtask

  task automatic push_sync(input int b);
    push(ps(b, 35, 0), 1'b0, mk(0, 0, 0, 0, 3'b0), "h35_idle");
    push(ps(b, 36, 0), 1'b0, mk(0, 1, 0, 0, 3'b0), "h36_hs");
    push(ps(b, 41, 0), 1'b0, mk(0, 1, 0, 0, 3'b0), "h41_hs");
    push(ps(b, 42, 0), 1'b0, mk(0, 0, 0, 0, 3'b0), "h42_idle");
    push(ps(b, 47, 17), 1'b0, mk(0, 0, 0, 0, 3'b0), "v17_idle");
    push(ps(b, 0, 18), 1'b0, mk(0, 0, 1, 0, 3'b0), "v18_vs");
    push(ps(b, 36, 19), 1'b0, mk(0, 1, 1, 0, 3'b0), "v19_hs_vs");
    push(ps(b, 47, 20), 1'b0, mk(0, 0, 1, 0, 3'b0), "v20_vs");
    push(ps(b, 0, 21), 1'b0, mk(0, 0, 0, 0, 3'b0), "v21_idle");
  endtask

  task automatic wr(input int wx, input int wy, input logic [2:0] c);
    x = 8'(wx);
    y = 7'(wy);
    colour = c;
    writeEn = 1'b1;
    @(negedge clk);
    writeEn = 1'b0;
  endtask

  task automatic to_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic wr_at(input int k, input int wx, input int wy, input logic [2:0] c);
    to_cyc(k - 1);
    wr(wx, wy, c);
  endtask

  always @(negedge clk) begin
    for (int i = q_at.size() - 1; i >= 0; i--)
      if (q_at[i] <= cyc) begin
        got = q_sel[i] ? obs_d : obs_s;
        compared++;
        if (q_at[i] < cyc || got !== q_exp[i]) begin
          mismatched++;
          $display("FAIL %s: got %h expected %h at cycle %0d", q_nm[i], got, q_exp[i], cyc);
        end
        q_at.delete(i);
        q_sel.delete(i);
        q_exp.delete(i);
        q_nm.delete(i);
      end
  end

  initial begin
    repeat (3) @(negedge clk);
    // fill the visible blocks while reset is held; writes must still land
    for (int wy = 0; wy < 4; wy++)
      for (int wx = 0; wx < 8; wx++) begin
        mdl[wy][wx] = (wx == 0 && wy == 0) ? 3'b100 : 3'((wx * 5 + wy * 3 + 1) % 8);
        wr(wx, wy, mdl[wy][wx]);
      end
    wr(160, 0, 3'b111);
    wr(0, 120, 3'b111);
    wr(159, 0, 3'b011);
    wr(159, 119, 3'b011);
    mdl[3][2] = 3'd1;
    @(negedge clk);
    r0 = cyc + 2;
    push(r0 - 1, 1'b0, mk(0, 0, 0, 0, 3'b0), "in_reset_s");
    push(r0 - 1, 1'b1, mk(0, 0, 0, 0, 3'b0), "in_reset_d");
    push_rst(r0);
    push_frame(r0, "f0");
    push_sync(r0);
    push(r0 + 5, 1'b1, mk(0, 0, 0, 1, 3'b100), "d_h0");
    push(r0 + 5 + 8, 1'b1, mk(0, 0, 0, 1, 3'b110), "d_h4");
    push(r0 + 5 + 2 * 636, 1'b1, mk(0, 0, 0, 1, 3'b011), "d_h636");
    push(r0 + 5 + 2 * 639, 1'b1, mk(0, 0, 0, 1, 3'b011), "d_h639");
    push(r0 + 5 + 2 * 640, 1'b1, mk(0, 0, 0, 0, 3'b0), "d_h640");
    push(r0 + 5 + 2 * 655, 1'b1, mk(0, 0, 0, 0, 3'b0), "d_h655");
    push(r0 + 5 + 2 * 656, 1'b1, mk(0, 1, 0, 0, 3'b0), "d_h656_hs");
    push(r0 + 5 + 2 * 751, 1'b1, mk(0, 1, 0, 0, 3'b0), "d_h751_hs");
    push(r0 + 5 + 2 * 752, 1'b1, mk(0, 0, 0, 0, 3'b0), "d_h752");
    @(negedge clk);
    reset = 1'b0;
    // same-cycle write on the last frame-0 read of block (1,0), then a write one cycle ahead of block (2,3)
    wr_at(r0 + 305, 1, 0, 3'b111);
    wr_at(r0 + 1170, 2, 3, 3'd1);
    mdl[0][1] = 3'b111;
    push_frame(r0 + 2304, "f1");
    push_sync(r0 + 2304);
    q = r0 + 5569;
    r2 = q + 1;
    push(q, 1'b0, mk(0, 0, 0, 0, 3'b0), "mid_rst_s");
    push(q, 1'b1, mk(0, 0, 0, 0, 3'b0), "mid_rst_d");
    push_rst(r2);
    push_frame(r2, "f2");
    push_sync(r2);
    to_cyc(q - 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    while (q_at.size() > 0 && cyc < r2 + 2400) @(negedge clk);
    if (q_at.size() > 0) begin
      $display("FAIL timeout: %0d expected outputs never reached", q_at.size());
      compared += q_at.size();
      mismatched += q_at.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/vga_framebuffer.md
# vga_framebuffer

Receiving end of the pixel-write interface driven by the note-drawing logic: accepts single-pixel writes (`writeEn`, `x`, `y`, `colour`) into a 160x120, 3-bit-per-pixel frame store and continuously scans the store out as a 640x480@60 Hz VGA signal. Each stored pixel is displayed as a 4x4 block. The block sits between the drawing FSMs and the board DAC/VGA connector. It replaces nothing upstream: writers see a write-only, always-ready sink.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixel ticks)
- `H_SYNC`, 96, hsync pulse width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, active lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width
- `V_BACK`, 33, vertical back porch

- `clk`  in  1  system clock, 50 MHz
- `reset`  in  1  synchronous, active-high
- `writeEn`  in  1  pixel write strobe, one pixel per cycle when high
- `x`  in  8  write column, valid 0..159
- `y`  in  7  write row, valid 0..119
- `colour`  in  3  {R,G,B} write data
- `vga_clk`  out  1  pixel clock, `clk`/2
- `vga_hs`  out  1  horizontal sync, active-low
- `vga_vs`  out  1  vertical sync, active-low
- `vga_blank_n`  out  1  low outside the visible area
- `vga_sync_n`  out  1  constant 0 (no sync-on-green)
- `vga_r`, `vga_g`, `vga_b`  out  8 each  channel intensity

## Operation
- Frame store: 19200 x 3-bit simple dual-port RAM, one write port, one read port, both on `clk`. Contents are not cleared by `reset`; the drawing side owns clearing.
- Write port: when `writeEn`=1 and `x`<160 and `y`<120, store `colour` at address `y*160 + x`, 15 bits, formed as `(y<<7)+(y<<5)+x`. Out-of-range coordinates are dropped silently. Writes are accepted every cycle with no back-pressure.
- Pixel tick: a 1-bit phase register toggles every `clk`. `tick` is high when phase=1. `vga_clk` is the phase register, so it rises on the same edge that raises `tick`.
- Counters advance only on `tick`:
  - `h_cnt` runs 0..799 and wraps to 0.
  - `v_cnt` runs 0..524. It increments when `h_cnt` wraps and wraps to 0 after 524.
- Visible area: `h_cnt`<640 and `v_cnt`<480.
- hsync is active when `h_cnt` is in 656..751. vsync is active when `v_cnt` is in 490..491. Both ranges are derived from the parameters.
- Read address: `(v_cnt>>2)*160 + (h_cnt>>2)`, computed only for visible positions. Outside the visible area the address is don't-care.
- Pipeline, on `tick` only:
  - Stage 1 registers the read address together with the visible/hs/vs flags for that position.
  - Stage 2 is the RAM registered read data plus the delayed flags.
  - Stage 3 is the output registers.
- Output mapping:
  - `vga_r = {8{pix[2]}}`, `vga_g = {8{pix[1]}}`, `vga_b = {8{pix[0]}}` when visible. All channels are 0 when not visible.
  - `vga_hs` and `vga_vs` are the inverted active flags.
  - `vga_blank_n` is the visible flag.
- Read/write collision: a write and a read to the same address in the same cycle return the old data (read-before-write). The new value shows from the next frame.

## Timing
- Reset values, held while `reset`=1 and for the first edge after it falls:
  - phase=0, `h_cnt`=0, `v_cnt`=0, pipeline flags cleared.
  - `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0, `vga_r`/`vga_g`/`vga_b`=0, `vga_clk`=0, `vga_sync_n`=0.
- Reset mid-frame: the next frame starts from (0,0) after reset is released. RAM contents are preserved, and a write asserted during reset is still performed.
- Write latency: 1 `clk`. The pixel becomes visible on the next scan of its 4x4 block.
- Scan latency: the outputs for counter position (h,v) appear exactly 3 ticks (6 `clk`) after the counters equal (h,v). Sync, blank and colour are mutually aligned.
- Frame period: 800x525 ticks = 840000 `clk`.
- hsync low for 96 ticks per line. vsync low for 2 lines (1600 ticks).

## Test plan
- Reset, then release: the first 6 clks after release show `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0 and RGB 0. The first `vga_blank_n`=1 arrives 6 clks after release, and the line shows 640 consecutive visible ticks.
- Write `x`=0, `y`=0, `colour`=3'b100, then scan: outputs for h 0..3 on lines 0..3 are `vga_r`=8'hFF, `vga_g`=0, `vga_b`=0. Position h=4 on line 0 shows the RAM's prior content.
- Write `x`=159, `y`=119, `colour`=3'b011: outputs for h 636..639 on lines 476..479 are `vga_g`=`vga_b`=8'hFF. A write to `x`=160, `y`=0, `colour`=3'b111 leaves the RAM unchanged, checked against a model of the stored values.
- Count ticks over one frame: hsync low for exactly 96 ticks starting 656 ticks after line start, 525 hsync pulses per vsync period, and vsync low for exactly 1600 ticks.
- Assert `reset` for 1 clk at `v_cnt`=300: counters return to 0, outputs return to their reset values, and previously written pixels reappear unchanged in the next frame.
- Collision case: write `colour`=3'b111 in the same cycle the read port addresses that pixel. The current frame shows the old value and the following frame shows 8'hFF on all channels.
